// File: rtl/spi_master_arbiter.sv
// Purpose : arbitrates two byte-stream requesters onto one SPI master engine,
//           with per-requester chip-select locking and a fixed CS-high gap
//           between ownerships.
// Latency : req_valid in IDLE -> spi_start in the 3rd cycle (IDLE, SETUP, OWN);
//           spi_done -> req_rvalid on the following cycle.
// Backpressure: req_valid is held until the req_ready pulse; a non-owner waits
//           for the current owner to release (lock and valid low) or time out.
// Ports   : core_clk/core_rst (async, active-high); req_lock/req_valid/
//           req_wdata0/req_wdata1 in; req_ready/req_rvalid/req_rdata/req_grant
//           out; spi_start/spi_txdata out, spi_done/spi_rxdata in to/from the
//           engine; spi_cs_n chip select; arb_timeout forced-release pulse.
// Option  : define SPI_ARB_TIMEOUT_EN to force release of an owner that sits
//           idle in OWN for TIMEOUT cycles.
module spi_master_arbiter #(
  parameter int TIMEOUT = 1023,
  parameter int CS_GAP  = 2
) (
  input  logic       core_clk,
  input  logic       core_rst,
  input  logic [1:0] req_lock,
  input  logic [1:0] req_valid,
  input  logic [7:0] req_wdata0,
  input  logic [7:0] req_wdata1,
  output logic [1:0] req_ready,
  output logic [1:0] req_rvalid,
  output logic [7:0] req_rdata,
  output logic [1:0] req_grant,
  output logic       spi_start,
  output logic [7:0] spi_txdata,
  input  logic       spi_done,
  input  logic [7:0] spi_rxdata,
  output logic       spi_cs_n,
  output logic       arb_timeout
);

  typedef enum logic [2:0] {IDLE, SETUP, OWN, XFER, GAP} state_t;

  state_t     state, state_nxt;
  logic       owner, owner_nxt;
  logic       last_grant;
  logic [3:0] gap_cnt;
  logic [1:0] eligible;
  logic       own_valid;
  logic       own_lock;
  logic [7:0] own_wdata;
  logic [1:0] own_onehot;
  logic       owned;
  logic       timeout_hit;

  assign eligible   = req_lock | req_valid;
  assign own_valid  = owner ? req_valid[1] : req_valid[0];
  assign own_lock   = owner ? req_lock[1]  : req_lock[0];
  assign own_wdata  = owner ? req_wdata1   : req_wdata0;
  assign own_onehot = owner ? 2'b10        : 2'b01;

  // Chip select and grant are live from SETUP through the last XFER.
  assign owned     = (state == SETUP) || (state == OWN) || (state == XFER);
  assign req_grant = owned ? own_onehot : 2'b00;
  assign spi_cs_n  = ~owned;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  // Counts idle OWN cycles; a launched byte restarts the count, XFER holds it.
  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      to_cnt <= '0;
    end else if (state == OWN) begin
      to_cnt <= own_valid ? '0 : to_cnt + 1'b1;
    end else if (state != XFER) begin
      to_cnt <= '0;
    end
  end

  // Fires on the TIMEOUT-th consecutive idle OWN cycle of a locked owner.
  assign timeout_hit = (state == OWN) && !own_valid && own_lock &&
                       (to_cnt == TW'(TIMEOUT - 1));
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT < 0);
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    owner_nxt   = owner;
    spi_start   = 1'b0;
    spi_txdata  = 8'h00;
    req_ready   = 2'b00;
    arb_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (eligible == 2'b11) begin
          // Tie: the requester that did not own the bus last goes first.
          owner_nxt = ~last_grant;
          state_nxt = SETUP;
        end else if (eligible[0]) begin
          owner_nxt = 1'b0;
          state_nxt = SETUP;
        end else if (eligible[1]) begin
          owner_nxt = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: state_nxt = OWN;
      OWN: begin
        if (own_valid) begin
          spi_start  = 1'b1;
          spi_txdata = own_wdata;
          req_ready  = own_onehot;
          state_nxt  = XFER;
        end else if (timeout_hit) begin
          arb_timeout = 1'b1;
          state_nxt   = GAP;
        end else if (!own_lock) begin
          state_nxt = GAP;
        end
      end
      XFER: begin
        if (spi_done) state_nxt = OWN;
      end
      GAP: begin
        if (gap_cnt == 4'(CS_GAP - 1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or posedge core_rst) begin
    if (core_rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      gap_cnt    <= 4'd0;
      req_rdata  <= 8'h00;
      req_rvalid <= 2'b00;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      req_rvalid <= 2'b00;
      if (state == OWN && state_nxt == GAP) last_grant <= owner;
      gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
      // spi_done is only meaningful while a byte is in flight.
      if (state == XFER && spi_done) begin
        req_rdata  <= spi_rxdata;
        req_rvalid <= own_onehot;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_arbiter.sv
module tb_spi_master_arbiter;

  localparam int CS_GAP  = 2;
  localparam int TIMEOUT = 8;
  localparam int ENG_LAT = 2;

  logic       core_clk = 1'b0;
  logic       core_rst;
  logic [1:0] req_lock, req_valid;
  logic [7:0] req_wdata0, req_wdata1;
  logic [1:0] req_ready, req_rvalid, req_grant;
  logic [7:0] req_rdata, spi_txdata, spi_rxdata;
  logic       spi_start, spi_done, spi_cs_n, arb_timeout;

  always #5 core_clk = ~core_clk;

  spi_master_arbiter #(.TIMEOUT(TIMEOUT), .CS_GAP(CS_GAP)) dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .req_lock(req_lock), .req_valid(req_valid),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_ready(req_ready), .req_rvalid(req_rvalid),
    .req_rdata(req_rdata), .req_grant(req_grant),
    .spi_start(spi_start), .spi_txdata(spi_txdata),
    .spi_done(spi_done), .spi_rxdata(spi_rxdata),
    .spi_cs_n(spi_cs_n), .arb_timeout(arb_timeout)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit cs_hist [0:8191];
  logic [1:0] rdy_seen = 2'b00;
  logic [1:0] prev_grant = 2'b00;
  int n_rdy0 = 0, n_rdy1 = 0, n_rv = 0, n_to = 0;
  int last_rv_cyc = 0, last_start_cyc = 0, to_cyc = 0, grant_cyc = 0;
  int sent_cyc = 0;
  int eng_cnt = 0;
  logic [7:0] eng_rx = 8'h00;
  int inject_req = 0, inject_ack = 0;

  typedef struct packed { logic [7:0] tx; logic [7:0] rx; } byte_t;
  typedef struct packed { logic [1:0] bitv; logic [7:0] rx; } rv_t;
  byte_t q0[$];
  byte_t q1[$];
  rv_t   rv_q[$];
  logic [1:0] grant_log[$];

  typedef struct { int who; logic [7:0] tx; logic [7:0] rx; logic [1:0] grant; } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor, scoreboard consumer and SPI engine model, all on the falling edge.
  initial begin
    byte_t e;
    rv_t   r;
    spi_done = 1'b0;
    spi_rxdata = 8'h00;
    forever begin
      @(negedge core_clk);
      cyc++;
      if (cyc < 8192) cs_hist[cyc] = spi_cs_n;
      rdy_seen = req_ready;
      if (req_ready[0]) n_rdy0++;
      if (req_ready[1]) n_rdy1++;
      chk("grant_onehot", 32'($countones(req_grant) <= 1), 1);
      spi_done = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          spi_done = 1'b1;
          spi_rxdata = eng_rx;
        end
      end
      if (inject_ack != inject_req) begin
        inject_ack = inject_req;
        spi_done = 1'b1;
        spi_rxdata = 8'hEE;
      end
      if (spi_start) begin
        last_start_cyc = cyc;
        chk("ready_is_owner", req_ready, req_grant);
        if (req_grant == 2'b01 && q0.size() > 0) begin
          e = q0.pop_front();
          chk("txdata0", spi_txdata, e.tx);
          rv_q.push_back({2'b01, e.rx});
          eng_cnt = ENG_LAT; eng_rx = e.rx;
        end else if (req_grant == 2'b10 && q1.size() > 0) begin
          e = q1.pop_front();
          chk("txdata1", spi_txdata, e.tx);
          rv_q.push_back({2'b10, e.rx});
          eng_cnt = ENG_LAT; eng_rx = e.rx;
        end else begin
          chk("start_expected", 0, 1);
        end
      end
      if (req_rvalid != 2'b00) begin
        n_rv++;
        last_rv_cyc = cyc;
        if (rv_q.size() > 0) begin
          r = rv_q.pop_front();
          chk("rvalid_bits", req_rvalid, r.bitv);
          chk("rdata", req_rdata, r.rx);
        end else begin
          chk("rvalid_unexpected", req_rvalid, 0);
        end
      end
      if (req_grant != 2'b00 && prev_grant == 2'b00) begin
        grant_log.push_back(req_grant);
        grant_cyc = cyc;
      end
      prev_grant = req_grant;
      if (arb_timeout) begin
        n_to++;
        to_cyc = cyc;
      end
      if (core_rst) begin
        eng_cnt = 0;
        q0.delete(); q1.delete(); rv_q.delete();
      end
    end
  end

  // One cycle step; accepted bytes are withdrawn right after their ready pulse.
  task automatic tick();
    @(posedge core_clk);
    #1;
    req_valid = req_valid & ~rdy_seen;
  endtask

  task automatic send(input int who, input logic [7:0] tx, input logic [7:0] rx);
    if (who == 0) begin req_wdata0 = tx; q0.push_back({tx, rx}); end
    else begin req_wdata1 = tx; q1.push_back({tx, rx}); end
    req_valid[who] = 1'b1;
    sent_cyc = cyc + 1;
  endtask

  task automatic wait_idle(input string name);
    int quiet = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (req_valid == 2'b00 && req_lock == 2'b00 && q0.size() == 0 && q1.size() == 0 &&
          rv_q.size() == 0 && spi_cs_n) quiet++;
      else quiet = 0;
      if (quiet >= CS_GAP + 2) return;
    end
    chk(name, 0, 1);
  endtask

  task automatic wait_clr(input int who, input string name);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!req_valid[who]) return;
    end
    chk(name, 0, 1);
  endtask

  task automatic wait_rv(input int target, input string name);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (n_rv >= target) return;
    end
    chk(name, n_rv, target);
  endtask

  task automatic wait_grant(input logic [1:0] g, input string name);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (req_grant == g) return;
    end
    chk(name, req_grant, g);
  endtask

  task automatic do_reset();
    core_rst = 1'b1;
    req_valid = 2'b00;
    req_lock = 2'b00;
    tick(); tick();
    core_rst = 1'b0;
  endtask

  initial begin
    vec_t vecs[5];
    int gl0, rvb, rvc, r0b, r1b, lg, highs;
    core_rst = 1'b1;
    req_valid = 2'b00; req_lock = 2'b00;
    req_wdata0 = 8'h00; req_wdata1 = 8'h00;
    #2;
    chk("reset_ctrl", {spi_cs_n, spi_start, req_ready, req_rvalid, req_grant, arb_timeout},
        {1'b1, 8'b0});
    chk("reset_rdata", req_rdata, 8'h00);
    chk("reset_txdata", spi_txdata, 8'h00);
    repeat (3) @(posedge core_clk);
    #1 core_rst = 1'b0;

    // Single uncontended bytes.
    vecs[0] = '{0, 8'h9F, 8'h93, 2'b01};
    vecs[1] = '{1, 8'hA5, 8'h5A, 2'b10};
    vecs[2] = '{0, 8'h00, 8'hFF, 2'b01};
    vecs[3] = '{1, 8'hFF, 8'h00, 2'b10};
    vecs[4] = '{0, 8'h3C, 8'hC3, 2'b01};
    for (int i = 0; i < 5; i++) begin
      gl0 = grant_log.size();
      rvb = n_rv;
      tick();
      send(vecs[i].who, vecs[i].tx, vecs[i].rx);
      wait_idle("vec_idle");
      chk("vec_latency", last_start_cyc - sent_cyc, 2);
      chk("vec_rv_count", n_rv - rvb, 1);
      if (grant_log.size() > gl0) chk("vec_grant", grant_log[gl0], vecs[i].grant);
      else chk("vec_grant_seen", 0, 1);
      chk("vec_gap", {cs_hist[last_rv_cyc], cs_hist[last_rv_cyc+1], cs_hist[last_rv_cyc+2]},
          3'b011);
    end

    // CS gap length, then IDLE before the next grant.
    rvb = n_rv;
    tick();
    send(0, 8'h9F, 8'h93);
    wait_rv(rvb + 1, "gap_rv_wait");
    rvc = last_rv_cyc;
    send(0, 8'h11, 8'h22);
    wait_idle("gap_idle");
    chk("gap_cs_high", {cs_hist[rvc+1], cs_hist[rvc+2], cs_hist[rvc+3]}, 3'b111);
    chk("gap_regrant_cycle", grant_cyc - rvc, CS_GAP + 2);

    // Round robin under contention.
    do_reset();
    gl0 = grant_log.size();
    tick();
    send(0, 8'hA1, 8'h1A); send(1, 8'hB2, 8'h2B);
    wait_idle("rr_idle1");
    tick();
    send(0, 8'hC3, 8'h3C); send(1, 8'hD4, 8'h4D);
    wait_idle("rr_idle2");
    if (grant_log.size() >= gl0 + 4) begin
      chk("rr_grant1", grant_log[gl0], 2'b01);
      chk("rr_grant2", grant_log[gl0+1], 2'b10);
      chk("rr_grant3", grant_log[gl0+2], 2'b01);
      chk("rr_grant4", grant_log[gl0+3], 2'b10);
    end else chk("rr_grant_count", grant_log.size() - gl0, 4);

    // Locked multi-byte burst with a competing non-owner.
    rvb = n_rv; r0b = n_rdy0; r1b = n_rdy1; gl0 = grant_log.size();
    tick();
    req_lock[1] = 1'b1;
    send(1, 8'h03, 8'hC0);
    wait_clr(1, "lock_b1");
    lg = grant_cyc;
    send(0, 8'h77, 8'h88);
    send(1, 8'h00, 8'hC1);
    wait_clr(1, "lock_b2");
    send(1, 8'h10, 8'hC2);
    wait_clr(1, "lock_b3");
    wait_rv(rvb + 3, "lock_rv_wait");
    highs = 0;
    for (int c = lg; c <= last_rv_cyc; c++) if (cs_hist[c]) highs++;
    chk("lock_cs_low", highs, 0);
    chk("lock_rdy1", n_rdy1 - r1b, 3);
    chk("lock_rdy0_blocked", n_rdy0 - r0b, 0);
    chk("lock_rv", n_rv - rvb, 3);
    chk("lock_still_owned", req_grant, 2'b10);
    req_lock[1] = 1'b0;
    wait_idle("lock_idle");
    if (grant_log.size() >= gl0 + 2) chk("lock_then_req0", grant_log[gl0+1], 2'b01);
    else chk("lock_grant_count", grant_log.size() - gl0, 2);

    // Locked idle owner with a pending requester.
    do_reset();
    tick();
    req_lock[0] = 1'b1;
    wait_grant(2'b01, "to_grant0");
    lg = grant_cyc;
    send(1, 8'h5A, 8'hA5);
`ifdef SPI_ARB_TIMEOUT_EN
    for (int i = 0; i < 60 && n_to == 0; i++) tick();
    chk("to_pulse", n_to, 1);
    chk("to_cycle", to_cyc - lg, TIMEOUT);
    chk("to_cs_high", cs_hist[to_cyc+1], 1'b1);
    wait_grant(2'b10, "to_grant1");
    chk("to_regrant_cycle", grant_cyc - to_cyc, CS_GAP + 2);
    req_lock[0] = 1'b0;
    wait_idle("to_idle");
    chk("to_single_pulse", n_to, 1);
`else
    repeat (40) tick();
    chk("no_timeout", n_to, 0);
    chk("lock_held", {spi_cs_n, req_grant}, 3'b001);
    req_lock[0] = 1'b0;
    wait_idle("hold_idle");
    chk("hold_then_req1", grant_log[grant_log.size()-1], 2'b10);
`endif

    // Reset while a byte is in flight, then a stray spi_done.
    tick();
    send(0, 8'hAA, 8'h55);
    wait_clr(0, "rst_start");
    rvb = n_rv;
    core_rst = 1'b1;
    #1;
    chk("rst_cs_n", spi_cs_n, 1'b1);
    chk("rst_rdata", req_rdata, 8'h00);
    chk("rst_grant", req_grant, 2'b00);
    tick();
    core_rst = 1'b0;
    inject_req++;
    repeat (8) tick();
    chk("rst_no_rvalid", n_rv - rvb, 0);
    chk("rst_idle", {spi_cs_n, req_grant}, 3'b100);

    chk("queues_empty", q0.size() + q1.size() + rv_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
